// File: rtl/urv_dmem_bridge_pkg.sv
// rtl/urv_dmem_bridge_pkg.sv - bridge state type and defaults built from urv_defs.v
`include "urv_defs.v"

package urv_dmem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = `URV_ST_IDLE,
    ST_WB_CYC  = `URV_ST_WB_CYC,
    ST_WB_DONE = `URV_ST_WB_DONE
  } state_t;

  localparam int WB_TIMEOUT_DEFAULT = `URV_WB_TIMEOUT_DEFAULT;

endpackage

// File: rtl/urv_defs.v
// rtl/urv_defs.v - shared FSM state encodings and Wishbone timeout default
`ifndef URV_DEFS_V
`define URV_DEFS_V

`define URV_ST_IDLE            2'd0
`define URV_ST_WB_CYC          2'd1
`define URV_ST_WB_DONE         2'd2
`define URV_WB_TIMEOUT_DEFAULT 255

`endif

// File: rtl/urv_dmem_ram.sv
// rtl/urv_dmem_ram.sv - single-port local data RAM, byte write enables, registered read
module urv_dmem_ram #(
  parameter int AW = 12
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
      rdata_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/urv_dmem_bridge.sv
// rtl/urv_dmem_bridge.sv - core data port to local RAM or Wishbone master
// Wishbone path present only when URV_DMEM_WB_EN is defined.
module urv_dmem_bridge
  import urv_dmem_bridge_pkg::*;
#(
  parameter int LOCAL_AW   = 14,
  parameter int WB_TIMEOUT = WB_TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        bus_error_o
);

  logic        req, is_local, is_load_only;
  logic        local_acc, ext_load_acc, err_set;
  logic [31:0] ext_data, ram_rdata;
  logic [3:0]  ram_we;
  logic        load_done_q, from_ram_q, bus_err_q;

  assign req          = dm_load_i | dm_store_i;
  assign is_local     = (dm_addr_i[31:LOCAL_AW] == '0);
  assign is_load_only = dm_load_i & ~dm_store_i;
  assign ram_we       = (local_acc & dm_store_i) ? dm_data_select_i : 4'b0000;

  urv_dmem_ram #(.AW(LOCAL_AW - 2)) u_ram (
    .clk_i   (clk_i),
    .en_i    (local_acc),
    .we_i    (ram_we),
    .addr_i  (dm_addr_i[LOCAL_AW-1:2]),
    .wdata_i (dm_data_s_i),
    .rdata_o (ram_rdata)
  );

`ifdef URV_DMEM_WB_EN
  localparam int TW = (WB_TIMEOUT > 1) ? $clog2(WB_TIMEOUT + 1) : 1;

  state_t        state, state_nx;
  logic [TW-1:0] tmo_cnt;
  logic [31:0]   adr_q, dat_q, ext_q;
  logic [3:0]    sel_q;
  logic          we_q, tmo_hit, latch_req, cyc_end;

  assign tmo_hit = (tmo_cnt == TW'(WB_TIMEOUT - 1));

  always_comb begin
    state_nx     = state;
    dm_ready_o   = 1'b0;
    local_acc    = 1'b0;
    ext_load_acc = 1'b0;
    latch_req    = 1'b0;
    cyc_end      = 1'b0;
    err_set      = 1'b0;
    case (state)
      ST_IDLE: begin
        dm_ready_o = is_local | ~req;
        if (req && is_local) begin
          local_acc = 1'b1;
        end else if (req) begin
          latch_req = 1'b1;
          state_nx  = ST_WB_CYC;
        end
      end
      ST_WB_CYC: begin
        // err wins over a simultaneous ack; timeout also reports as error
        if (wb_ack_i || wb_err_i || tmo_hit) begin
          cyc_end  = 1'b1;
          err_set  = wb_err_i | ~wb_ack_i;
          state_nx = ST_WB_DONE;
        end
      end
      ST_WB_DONE: begin
        dm_ready_o   = 1'b1;
        ext_load_acc = is_load_only;
        state_nx     = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
      we_q    <= 1'b0;
      ext_q   <= '0;
    end else begin
      state   <= state_nx;
      tmo_cnt <= (state == ST_WB_CYC && !cyc_end) ? tmo_cnt + 1'b1 : '0;
      if (latch_req) begin
        adr_q <= dm_addr_i;
        dat_q <= dm_data_s_i;
        sel_q <= dm_data_select_i;
        we_q  <= dm_store_i;
      end
      if (cyc_end) ext_q <= (wb_ack_i && !wb_err_i) ? wb_dat_i : '0;
    end
  end

  assign wb_cyc_o = (state == ST_WB_CYC);
  assign wb_stb_o = wb_cyc_o;
  assign wb_we_o  = wb_cyc_o & we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;
  assign ext_data = ext_q;
`else
  // External accesses complete at once: stores dropped, loads read zero, error flagged
  always_comb begin
    dm_ready_o   = 1'b1;
    local_acc    = req & is_local;
    ext_load_acc = req & ~is_local & is_load_only;
    err_set      = req & ~is_local;
  end

  assign wb_cyc_o = 1'b0;
  assign wb_stb_o = 1'b0;
  assign wb_we_o  = 1'b0;
  assign wb_adr_o = '0;
  assign wb_dat_o = '0;
  assign wb_sel_o = '0;
  assign ext_data = '0;

  logic unused_wb;
  assign unused_wb = ^{wb_dat_i, wb_ack_i, wb_err_i, 32'(WB_TIMEOUT)};
`endif

  logic unused_addr;
  assign unused_addr = ^dm_addr_i[1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      load_done_q <= 1'b0;
      bus_err_q   <= 1'b0;
      from_ram_q  <= 1'b0;
    end else begin
      load_done_q <= (local_acc & is_load_only) | ext_load_acc;
      bus_err_q   <= err_set;
      if (local_acc && is_load_only) from_ram_q <= 1'b1;
      else if (ext_load_acc)         from_ram_q <= 1'b0;
    end
  end

  assign dm_load_done_o = load_done_q;
  assign dm_data_l_o    = from_ram_q ? ram_rdata : ext_data;
  assign bus_error_o    = bus_err_q;

endmodule

// File: tb/tb_urv_dmem_bridge.sv
// tb/tb_urv_dmem_bridge.sv - self-checking bench for urv_dmem_bridge
module tb_urv_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] dm_addr_i, dm_data_s_i;
  logic [3:0]  dm_data_select_i;
  logic        dm_store_i, dm_load_i;
  logic        dm_ready_o, dm_load_done_o;
  logic [31:0] dm_data_l_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;
  logic        bus_error_o;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] BASE = 32'h0000_0100;
  logic [31:0] model [16];

  urv_dmem_bridge #(.LOCAL_AW(14), .WB_TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i),
    .dm_data_select_i(dm_data_select_i), .dm_store_i(dm_store_i),
    .dm_load_i(dm_load_i), .dm_ready_o(dm_ready_o),
    .dm_data_l_o(dm_data_l_o), .dm_load_done_o(dm_load_done_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .bus_error_o(bus_error_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic st, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    dm_load_i = ld; dm_store_i = st; dm_addr_i = a; dm_data_s_i = d; dm_data_select_i = s;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // One accepted single-cycle access with its next-cycle outcome
  task automatic access(input string tag, input logic ld, input logic st,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic exp_done, input logic [31:0] exp_data, input logic exp_err);
    drive(ld, st, a, d, s);
    #1;
    check({tag, "_ready"}, dm_ready_o, 1'b1);
    tick();
    check({tag, "_done"}, dm_load_done_o, exp_done);
    if (exp_done) check({tag, "_data"}, dm_data_l_o, exp_data);
    check({tag, "_err"}, bus_error_o, exp_err);
    check({tag, "_cyc"}, wb_cyc_o, 1'b0);
  endtask

  task automatic local_access(input string tag, input logic ld, input logic st,
                              input int w, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] a;
    a = BASE + 32'(w * 4) + 32'($urandom_range(0, 3));
    access(tag, ld, st, a, d, s, ld & ~st, model[w], 1'b0);
    if (st) model[w] = merge(model[w], d, s);
  endtask

  initial begin
    int op, w, dly, cnt;
    logic ld, st;
    logic [31:0] d, rd, xa;

    rst_i = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    tick(); tick();
    check("rst_cyc", wb_cyc_o, 1'b0);
    check("rst_stb", wb_stb_o, 1'b0);
    check("rst_we", wb_we_o, 1'b0);
    check("rst_done", dm_load_done_o, 1'b0);
    check("rst_err", bus_error_o, 1'b0);
    check("rst_data", dm_data_l_o, 32'h0);
    rst_i = 1'b0;

    for (int i = 0; i < 16; i++) begin
      model[i] = 32'h0;
      local_access("init", 1'b0, 1'b1, i, $urandom, 4'hF);
    end

    local_access("st_dead", 1'b0, 1'b1, 0, 32'hDEAD_BEEF, 4'b1111);
    local_access("ld_dead", 1'b1, 1'b0, 0, 32'h0, 4'h0);
    check("dead_value", dm_data_l_o, 32'hDEAD_BEEF);
    local_access("st_aa", 1'b0, 1'b1, 0, 32'h0000_00AA, 4'b0001);
    local_access("ld_aa", 1'b1, 1'b0, 0, 32'h0, 4'h0);
    check("aa_value", dm_data_l_o, 32'hDEAD_BEAA);

    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 3);
      w  = $urandom_range(0, 15);
      local_access("rnd", op == 1 || op == 3, op >= 2, w, $urandom, 4'($urandom_range(0, 15)));
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

`ifdef URV_DMEM_WB_EN
    for (int n = 0; n < 6; n++) begin
      st  = n[0];
      ld  = ~st | n[1];
      dly = (n == 0) ? 3 : $urandom_range(1, 5);
      rd  = (n == 0) ? 32'h1234_5678 : $urandom;
      d   = $urandom;
      xa  = $urandom;
      xa  = (n == 0) ? 32'h8000_0000 : {1'b1, xa[30:0]};
      drive(ld, st, xa, d, 4'hF);
      #1;
      check("ext_ready_idle", dm_ready_o, 1'b0);
      tick();
      cnt = 0;
      for (int c = 1; c <= dly; c++) begin
        check("ext_cyc", wb_cyc_o, 1'b1);
        check("ext_stb", wb_stb_o, 1'b1);
        check("ext_adr", wb_adr_o, xa);
        check("ext_we", wb_we_o, st);
        if (st) check("ext_dat", wb_dat_o, d);
        if (wb_cyc_o) cnt++;
        dm_addr_i = $urandom_range(0, 255) * 4;
        if (c == dly) begin wb_ack_i = 1'b1; wb_dat_i = rd; end
        tick();
        wb_ack_i = 1'b0;
      end
      check("ext_cyc_len", cnt, dly);
      check("ext_cyc_drop", wb_cyc_o, 1'b0);
      check("ext_ready_done", dm_ready_o, 1'b1);
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      check("ext_done", dm_load_done_o, ~st);
      if (!st) check("ext_data", dm_data_l_o, rd);
      check("ext_noerr", bus_error_o, 1'b0);
    end

    drive(1'b0, 1'b1, 32'h9000_0000, 32'h1111_2222, 4'hF);
    tick();
    cnt = 0;
    for (int c = 0; c < 40 && wb_cyc_o; c++) begin cnt++; tick(); end
    check("tmo_len", cnt, 8);
    check("tmo_cyc_drop", wb_cyc_o, 1'b0);
    check("tmo_err", bus_error_o, 1'b1);
    check("tmo_ready", dm_ready_o, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("tmo_err_pulse", bus_error_o, 1'b0);
    check("tmo_done", dm_load_done_o, 1'b0);

    drive(1'b1, 1'b0, 32'hA000_0000, 32'h0, 4'hF);
    tick();
    wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
    tick();
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    check("err_flag", bus_error_o, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("err_done", dm_load_done_o, 1'b1);
    check("err_data", dm_data_l_o, 32'h0);

    drive(1'b1, 1'b0, 32'hB000_0000, 32'h0, 4'hF);
    tick();
    wb_ack_i = 1'b1; wb_dat_i = 32'h5555_AAAA;
    tick();
    wb_ack_i = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    check("kill_ready", dm_ready_o, 1'b1);
    tick();
    check("kill_done", dm_load_done_o, 1'b0);
    local_access("kill_after", 1'b1, 1'b0, 3, 32'h0, 4'h0);

    drive(1'b1, 1'b0, 32'hC000_0000, 32'h0, 4'hF);
    tick();
    tick();
    check("rstmid_cyc2", wb_cyc_o, 1'b1);
    rst_i = 1'b1;
    tick();
    check("rstmid_drop", wb_cyc_o, 1'b0);
    rst_i = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    check("rstmid_done", dm_load_done_o, 1'b0);
    local_access("rstmid_ram", 1'b1, 1'b0, 0, 32'h0, 4'h0);
`else
    access("nowb_ld", 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1);
    access("nowb_st", 1'b0, 1'b1, 32'h8000_0100, 32'h5555_5555, 4'hF, 1'b0, 32'h0, 1'b1);
    for (int n = 0; n < 8; n++) begin
      xa = $urandom;
      access("nowb_rnd", 1'b1, 1'b0, {1'b1, xa[30:0]}, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1);
    end
    local_access("nowb_local", 1'b1, 1'b0, 0, 32'h0, 4'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    check("nowb_err_pulse", bus_error_o, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
